// File: rtl/mouse_pkg.sv
// Shared definitions for the PS/2 mouse receive path: receiver states,
// error-flag bit positions and frame geometry.
package mouse_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int ERR_PARITY     = 0;
    localparam int ERR_STOP       = 1;
    localparam int PS2_FRAME_BITS = 11;
    // Start, parity and stop bits surround the payload.
    localparam int PS2_DATA_BITS  = PS2_FRAME_BITS - 3;

endpackage

// File: rtl/ps2_line_sync.sv
// Brings the raw PS/2 clock and data lines into the CLK domain and flags
// falling edges of the mouse clock.
module ps2_line_sync (
    input  logic CLK,
    input  logic RESET,
    input  logic CLK_MOUSE_IN,
    input  logic DATA_MOUSE_IN,
    output logic fall,
    output logic data_sync
);

    logic [1:0] clk_sync_reg;
    logic       clk_dly_reg;
    logic [1:0] data_sync_reg;

    // Idle PS/2 lines float high, so the flops reset to 1 to avoid a false edge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            clk_sync_reg  <= 2'b11;
            clk_dly_reg   <= 1'b1;
            data_sync_reg <= 2'b11;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[0], CLK_MOUSE_IN};
            clk_dly_reg   <= clk_sync_reg[1];
            data_sync_reg <= {data_sync_reg[0], DATA_MOUSE_IN};
        end
    end

    assign fall      = clk_dly_reg & ~clk_sync_reg[1];
    assign data_sync = data_sync_reg[1];

endmodule

// File: rtl/mouse_receiver.sv
// PS/2 device-to-host frame receiver with abort on READ_ENABLE loss and a
// watchdog that discards truncated frames.
module mouse_receiver
    import mouse_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CLK_MOUSE_IN,
    input  logic       DATA_MOUSE_IN,
    input  logic       READ_ENABLE,
    output logic [7:0] BYTE_READ,
    output logic [1:0] BYTE_ERROR_CODE,
    output logic       BYTE_READY
);

    localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
    localparam int CNT_W = $clog2(PS2_DATA_BITS);

    logic fall;
    logic data_sync;

    ps2_line_sync u_sync (
        .CLK           (CLK),
        .RESET         (RESET),
        .CLK_MOUSE_IN  (CLK_MOUSE_IN),
        .DATA_MOUSE_IN (DATA_MOUSE_IN),
        .fall          (fall),
        .data_sync     (data_sync)
    );

    rx_state_t                  state_reg,  state_next;
    logic [CNT_W-1:0]           bit_cnt_reg, bit_cnt_next;
    logic [PS2_DATA_BITS-1:0]   shift_reg,  shift_next;
    logic                       parity_reg, parity_next;
    logic [WD_W-1:0]            wd_reg,     wd_next;
    logic [7:0]                 byte_reg,   byte_next;
    logic [1:0]                 err_reg,    err_next;
    logic                       ready_reg,  ready_next;
    logic                       timeout;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            parity_reg  <= 1'b0;
            wd_reg      <= '0;
            byte_reg    <= 8'h00;
            err_reg     <= 2'b00;
            ready_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            parity_reg  <= parity_next;
            wd_reg      <= wd_next;
            byte_reg    <= byte_next;
            err_reg     <= err_next;
            ready_reg   <= ready_next;
        end
    end

    assign timeout = (wd_reg == WD_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        parity_next  = parity_reg;
        byte_next    = byte_reg;
        err_next     = err_reg;
        ready_next   = 1'b0;

        // Saturating watchdog, restarted by every mouse clock edge.
        if (state_reg == IDLE || fall)
            wd_next = '0;
        else if (wd_reg != '1)
            wd_next = wd_reg + 1'b1;
        else
            wd_next = wd_reg;

        if (state_reg != IDLE && !READ_ENABLE) begin
            state_next = IDLE;
        end else if (state_reg != IDLE && timeout) begin
            state_next = IDLE;
        end else if (fall) begin
            case (state_reg)
                IDLE: begin
                    if (!data_sync && READ_ENABLE) begin
                        state_next   = DATA;
                        bit_cnt_next = '0;
                    end
                end
                DATA: begin
                    shift_next   = {data_sync, shift_reg[PS2_DATA_BITS-1:1]};
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                    if (bit_cnt_reg == CNT_W'(PS2_DATA_BITS - 1))
                        state_next = PARITY;
                end
                PARITY: begin
                    parity_next = data_sync;
                    state_next  = STOP;
                end
                STOP: begin
                    byte_next            = shift_reg;
                    err_next[ERR_PARITY] = ~(^{shift_reg, parity_reg});
                    err_next[ERR_STOP]   = ~data_sync;
                    ready_next           = 1'b1;
                    state_next           = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign BYTE_READ       = byte_reg;
    assign BYTE_ERROR_CODE = err_reg;
    assign BYTE_READY      = ready_reg;

endmodule

// File: tb/tb_mouse_receiver.sv
// Directed and randomised PS/2 frames against a frame-level reference model.
module tb_mouse_receiver;
    import mouse_pkg::*;

    localparam int TIMEOUT = 200;
    localparam int HALF    = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic       read_en;
    logic [7:0] byte_read;
    logic [1:0] err_code;
    logic       byte_ready;

    int vectors     = 0;
    int miscompares = 0;
    int pulses      = 0;
    int exp_pulses  = 0;
    int back_to_back = 0;
    logic prev_ready = 1'b0;

    logic [7:0] exp_byte;
    logic [1:0] exp_code;

    mouse_receiver #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .CLK             (clk),
        .RESET           (rst),
        .CLK_MOUSE_IN    (ps2_clk),
        .DATA_MOUSE_IN   (ps2_data),
        .READ_ENABLE     (read_en),
        .BYTE_READ       (byte_read),
        .BYTE_ERROR_CODE (err_code),
        .BYTE_READY      (byte_ready)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (byte_ready === 1'b1) begin
            pulses++;
            if (prev_ready === 1'b1) back_to_back++;
        end
        prev_ready = byte_ready;
    end

    // Reference: odd parity over data+parity must hold; stop bit must be 1.
    function automatic logic [1:0] ref_code(input logic [7:0] d, input logic p, input logic s);
        int ones;
        ones = $countones(d) + int'(p);
        ref_code = {(s == 1'b0), (ones % 2 == 0)};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One PS/2 bit: data changes mid-high, then a HALF-long low phase.
    task automatic ps2_bit(input logic b, input logic last);
        @(negedge clk);
        ps2_data = b;
        repeat (HALF / 2) @(negedge clk);
        ps2_clk = 1'b0;
        if (last) begin
            @(posedge clk);
            @(posedge clk); #1;
            chk("ready_early", {7'd0, byte_ready}, 8'd0);
            @(posedge clk); #1;
            chk("ready_pulse", {7'd0, byte_ready}, 8'd1);
            chk("byte_read", byte_read, exp_byte);
            chk("err_code", {6'd0, err_code}, {6'd0, exp_code});
            @(posedge clk); #1;
            chk("ready_late", {7'd0, byte_ready}, 8'd0);
            repeat (HALF - 3) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
        ps2_clk = 1'b1;
        repeat (HALF / 2) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int nbits);
        logic [PS2_FRAME_BITS-1:0] bits;
        bits = {s, p, d, 1'b0};
        if (nbits == PS2_FRAME_BITS) begin
            exp_byte = d;
            exp_code = ref_code(d, p, s);
            exp_pulses++;
        end
        for (int i = 0; i < nbits; i++)
            ps2_bit(bits[i], i == PS2_FRAME_BITS - 1);
        ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        chk("pulse_count", 8'(pulses), 8'(exp_pulses));
        if (nbits == PS2_FRAME_BITS) chk("byte_hold", byte_read, exp_byte);
    endtask

    initial begin
        logic [7:0] d;
        logic       p, s;

        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; read_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_byte", byte_read, 8'h00);
        chk("rst_code", {6'd0, err_code}, 8'd0);
        chk("rst_ready", {7'd0, byte_ready}, 8'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        send_frame(8'hA5, 1'b1, 1'b1, PS2_FRAME_BITS);
        send_frame(8'h3C, 1'b0, 1'b1, PS2_FRAME_BITS);
        send_frame(8'hFA, 1'b1, 1'b0, PS2_FRAME_BITS);

        // Truncated frame recovered by the watchdog.
        send_frame(8'h00, 1'b0, 1'b1, 6);
        repeat (250) @(negedge clk);
        chk("trunc_no_pulse", 8'(pulses), 8'(exp_pulses));
        send_frame(8'hFA, 1'b1, 1'b1, PS2_FRAME_BITS);

        // READ_ENABLE abort; next frame follows well inside the watchdog window.
        send_frame(8'h00, 1'b0, 1'b1, 5);
        read_en = 1'b0;
        repeat (5) @(negedge clk);
        read_en = 1'b1;
        chk("abort_no_pulse", 8'(pulses), 8'(exp_pulses));
        send_frame(8'h08, 1'b0, 1'b1, PS2_FRAME_BITS);

        // Asynchronous reset mid-frame.
        send_frame(8'hFF, 1'b0, 1'b1, 8);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_byte", byte_read, 8'h00);
        chk("mid_rst_code", {6'd0, err_code}, 8'd0);
        chk("mid_rst_ready", {7'd0, byte_ready}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        send_frame(8'h55, 1'b1, 1'b1, PS2_FRAME_BITS);

        // Idle glitch: a clock fall with data high must be ignored.
        ps2_bit(1'b1, 1'b0);
        chk("glitch_no_pulse", 8'(pulses), 8'(exp_pulses));
        send_frame(8'h6E, 1'b0, 1'b1, PS2_FRAME_BITS);

        for (int n = 0; n < 8; n++) begin
            d = 8'($urandom);
            p = 1'($urandom_range(0, 1));
            s = ($urandom_range(0, 3) != 0);
            send_frame(d, p, s, PS2_FRAME_BITS);
        end

        chk("back_to_back", 8'(back_to_back), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
